// File: rtl/arch_state_loader.sv
// arch_state_loader: preloads architectural register state before the OoO core
// is released. Streams one word per architectural register into the PRF,
// programs an identity mapping into the front RAT, then seeds the free list
// with the remaining physical registers. The core is held in reset (cpu_hold)
// until the sequence finishes.
//
// Optional feature (macro ARCH_LOADER_CHECKSUM_EN): adds a checksum output
// holding the running XOR of every accepted in_data word (x0 as received).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet, cpu_hold keeps last value
// LOAD   | accepting one word per arch register, PRF + RAT write each
// SEED   | pushing physical registers ARCH_REGS..PHY_REGS-1 to free list
// DONE   | one-cycle completion: load_done pulse, release cpu_hold

module arch_state_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int PHY_REGS   = 64,
    parameter int PHY_WIDTH  = 6,
    parameter int ARCH_REGS  = 32,
    parameter int ARCH_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  prf_we,
    output logic [PHY_WIDTH-1:0]  prf_waddr,
    output logic [DATA_WIDTH-1:0] prf_wdata,
    output logic                  rat_we,
    output logic [ARCH_WIDTH-1:0] rat_arch,
    output logic [PHY_WIDTH-1:0]  rat_phys,
    output logic                  fl_push,
    output logic [PHY_WIDTH-1:0]  fl_reg,
    output logic                  busy,
    output logic                  load_done,
`ifdef ARCH_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  cpu_hold
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEED = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ARCH_WIDTH-1:0] IDX_LAST   = ARCH_WIDTH'(ARCH_REGS - 1);
    // fidx carries one extra bit so counting up to PHY_REGS never wraps
    localparam logic [PHY_WIDTH:0]    FIDX_FIRST = (PHY_WIDTH + 1)'(ARCH_REGS);
    localparam logic [PHY_WIDTH:0]    FIDX_LAST  = (PHY_WIDTH + 1)'(PHY_REGS - 1);
    localparam bit                    SKIP_SEED  = (ARCH_REGS == PHY_REGS);

    state_t                state_q, state_d;
    logic [ARCH_WIDTH-1:0] idx_q, idx_d;
    logic [PHY_WIDTH:0]    fidx_q, fidx_d;
    logic                  in_ready_q, in_ready_d;
    logic                  prf_we_q, prf_we_d;
    logic [PHY_WIDTH-1:0]  prf_waddr_q, prf_waddr_d;
    logic [DATA_WIDTH-1:0] prf_wdata_q, prf_wdata_d;
    logic                  rat_we_q, rat_we_d;
    logic [ARCH_WIDTH-1:0] rat_arch_q, rat_arch_d;
    logic [PHY_WIDTH-1:0]  rat_phys_q, rat_phys_d;
    logic                  fl_push_q, fl_push_d;
    logic [PHY_WIDTH-1:0]  fl_reg_q, fl_reg_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  cpu_hold_q, cpu_hold_d;
`ifdef ARCH_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
`endif

    logic accept;

    // A word transfers when the registered ready is seen together with valid in LOAD
    assign accept = (state_q == S_LOAD) && in_valid && in_ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fidx_d      = fidx_q;
        in_ready_d  = 1'b0;
        prf_we_d    = 1'b0;
        prf_waddr_d = prf_waddr_q;
        prf_wdata_d = prf_wdata_q;
        rat_we_d    = 1'b0;
        rat_arch_d  = rat_arch_q;
        rat_phys_d  = rat_phys_q;
        fl_push_d   = 1'b0;
        fl_reg_d    = fl_reg_q;
        busy_d      = busy_q;
        load_done_d = 1'b0;
        cpu_hold_d  = cpu_hold_q;
`ifdef ARCH_LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                    in_ready_d = 1'b1;
`ifdef ARCH_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end

            S_LOAD: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    prf_we_d    = 1'b1;
                    prf_waddr_d = PHY_WIDTH'(idx_q);
                    // x0 is architecturally zero whatever the stream carries
                    prf_wdata_d = (idx_q == '0) ? '0 : in_data;
                    rat_we_d    = 1'b1;
                    rat_arch_d  = idx_q;
                    rat_phys_d  = PHY_WIDTH'(idx_q);
`ifdef ARCH_LOADER_CHECKSUM_EN
                    checksum_d  = checksum_q ^ in_data;
`endif
                    if (idx_q == IDX_LAST) begin
                        in_ready_d = 1'b0;
                        fidx_d     = FIDX_FIRST;
                        state_d    = SKIP_SEED ? S_DONE : S_SEED;
                    end else begin
                        idx_d = idx_q + ARCH_WIDTH'(1);
                    end
                end
            end

            S_SEED: begin
                fl_push_d = 1'b1;
                fl_reg_d  = fidx_q[PHY_WIDTH-1:0];
                fidx_d    = fidx_q + (PHY_WIDTH + 1)'(1);
                if (fidx_q == FIDX_LAST) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                load_done_d = 1'b1;
                busy_d      = 1'b0;
                cpu_hold_d  = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts everything and re-holds the core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            fidx_q      <= '0;
            in_ready_q  <= 1'b0;
            prf_we_q    <= 1'b0;
            prf_waddr_q <= '0;
            prf_wdata_q <= '0;
            rat_we_q    <= 1'b0;
            rat_arch_q  <= '0;
            rat_phys_q  <= '0;
            fl_push_q   <= 1'b0;
            fl_reg_q    <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            cpu_hold_q  <= 1'b1;
`ifdef ARCH_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fidx_q      <= fidx_d;
            in_ready_q  <= in_ready_d;
            prf_we_q    <= prf_we_d;
            prf_waddr_q <= prf_waddr_d;
            prf_wdata_q <= prf_wdata_d;
            rat_we_q    <= rat_we_d;
            rat_arch_q  <= rat_arch_d;
            rat_phys_q  <= rat_phys_d;
            fl_push_q   <= fl_push_d;
            fl_reg_q    <= fl_reg_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            cpu_hold_q  <= cpu_hold_d;
`ifdef ARCH_LOADER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign prf_we    = prf_we_q;
    assign prf_waddr = prf_waddr_q;
    assign prf_wdata = prf_wdata_q;
    assign rat_we    = rat_we_q;
    assign rat_arch  = rat_arch_q;
    assign rat_phys  = rat_phys_q;
    assign fl_push   = fl_push_q;
    assign fl_reg    = fl_reg_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign cpu_hold  = cpu_hold_q;
`ifdef ARCH_LOADER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_arch_state_loader.sv
// Testbench for arch_state_loader: randomized/stated stream stimulus, expected
// PRF/RAT writes and free-list pushes queued from a reference model, checked
// by an independent monitor on the falling edge.
module tb_arch_state_loader;

    localparam int DW = 32;
    localparam int PR = 64;
    localparam int PW = 6;
    localparam int AR = 32;
    localparam int AW = 5;

    localparam int M_STEADY = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_RAND   = 2;

    localparam int K_INC  = 0;
    localparam int K_A5   = 1;
    localparam int K_RAND = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          prf_we;
    logic [PW-1:0] prf_waddr;
    logic [DW-1:0] prf_wdata;
    logic          rat_we;
    logic [AW-1:0] rat_arch;
    logic [PW-1:0] rat_phys;
    logic          fl_push;
    logic [PW-1:0] fl_reg;
    logic          busy;
    logic          load_done;
    logic          cpu_hold;
`ifdef ARCH_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    arch_state_loader #(
        .DATA_WIDTH(DW), .PHY_REGS(PR), .PHY_WIDTH(PW),
        .ARCH_REGS(AR), .ARCH_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .prf_we(prf_we), .prf_waddr(prf_waddr), .prf_wdata(prf_wdata),
        .rat_we(rat_we), .rat_arch(rat_arch), .rat_phys(rat_phys),
        .fl_push(fl_push), .fl_reg(fl_reg),
        .busy(busy), .load_done(load_done),
`ifdef ARCH_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           wr_q[$];
    int            fl_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            exp_done = -1;
    bit            done_seen = 1'b0;
    logic [DW-1:0] exp_ck;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: consume expected writes/pushes whenever the DUT strobes
    always @(negedge clk) begin
        if (!rst) begin
            if (prf_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_prf_we", prf_we, 0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk("prf_waddr", prf_waddr, e.addr);
                    chk("prf_wdata", prf_wdata, e.data);
                    chk("rat_we", rat_we, 1);
                    chk("rat_arch", rat_arch, e.addr);
                    chk("rat_phys", rat_phys, e.addr);
                end
            end else if (rat_we) begin
                chk("rat_we_without_prf_we", rat_we, 0);
            end
            if (fl_push) begin
                chk("push_before_last_write", wr_q.size(), 0);
                if (fl_q.size() == 0) chk("unexpected_fl_push", fl_push, 0);
                else chk("fl_reg", fl_reg, fl_q.pop_front());
            end
            if (load_done) begin
                chk("done_cycle", cyc, exp_done);
                chk("done_cpu_hold", cpu_hold, 0);
                chk("done_busy", busy, 0);
                chk("writes_outstanding", wr_q.size(), 0);
                chk("pushes_outstanding", fl_q.size(), 0);
`ifdef ARCH_LOADER_CHECKSUM_EN
                chk("checksum", checksum, exp_ck);
`endif
                done_seen = 1'b1;
            end
        end
    end

    // One full load; abort_k/restart_k < 0 disable the reset/stray-start events
    task automatic do_load(input int mode, input int kind, input int abort_k, input int restart_k);
        logic [DW-1:0] w[AR];
        int k, guard, last_acc, entry, g;
        bit v;
        exp_ck = '0;
        for (int i = 0; i < AR; i++) begin
            case (kind)
                K_INC:   w[i] = 32'h1000_0000 + i;
                K_A5:    w[i] = 32'hA5A5_0000 ^ i;
                default: w[i] = $urandom;
            endcase
            exp_ck ^= w[i];
            wr_q.push_back({PW'(i), (i == 0) ? '0 : w[i]});
        end
        for (int f = AR; f < PR; f++) fl_q.push_back(f);
        done_seen = 1'b0;
        exp_done  = -1;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        entry = cyc;
        chk("start_cpu_hold", cpu_hold, 1);
        chk("start_busy", busy, 1);
        chk("start_in_ready", in_ready, 1);

        k = 0; guard = 0; last_acc = entry;
        while (k < AR && guard < 2000) begin
            if (k == abort_k) begin
                #2 rst = 1'b1;
                wr_q.delete();
                fl_q.delete();
                #1;
                chk("abort_strobes", {prf_we, rat_we, fl_push, load_done}, 4'b0);
                chk("abort_cpu_hold", cpu_hold, 1);
                chk("abort_busy", busy, 0);
                chk("abort_in_ready", in_ready, 0);
                in_valid = 1'b0;
                start = 1'b0;
                @(negedge clk) rst = 1'b0;
                @(negedge clk);
                chk("post_abort_cpu_hold", cpu_hold, 1);
                return;
            end
            case (mode)
                M_STEADY: v = 1'b1;
                M_TOGGLE: v = (guard % 2 == 0);
                default:  v = 1'($urandom_range(0, 1));
            endcase
            start    = (k == restart_k);
            in_valid = v;
            in_data  = w[k];
            if (v && in_ready) begin
                k++;
                last_acc = cyc + 1;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("accepted_words", k, AR);
        chk("in_ready_after_last", in_ready, 0);
        if (mode == M_TOGGLE) chk("toggle_load_span", last_acc - entry, 2 * AR - 1);
        exp_done = last_acc + (PR - AR) + 1;

        g = 0;
        while (!done_seen && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!done_seen) chk("load_done_timeout", done_seen, 1);
        @(negedge clk);
        chk("load_done_pulse_width", load_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_strobes", {prf_we, rat_we, fl_push, load_done}, 4'b0);
        rst = 1'b0;
        @(negedge clk);
        // in_valid outside LOAD must be ignored
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", in_ready, 0);
        chk("idle_prf_we", prf_we, 0);
        in_valid = 1'b0;

        do_load(M_STEADY, K_INC, -1, -1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_cpu_hold_low", cpu_hold, 0);
        end
        do_load(M_TOGGLE, K_RAND, -1, -1);
        do_load(M_STEADY, K_RAND, -1, 10);
        do_load(M_RAND,   K_RAND, 17, -1);
        do_load(M_STEADY, K_A5,   -1, -1);
        do_load(M_RAND,   K_RAND, -1, -1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arch_state_loader.md
Name: arch_state_loader

Overview:
- Preloads the architectural register state before the out-of-order core starts. It is the write-side counterpart of the architectural-state readout (PRF data plus front RAT).
- Accepts one data word per architectural register over a valid/ready stream. Writes each word into the PRF, programs the front RAT to an identity map, then seeds the free list with the remaining physical registers.
- Holds the CPU in reset (cpu_hold) until loading completes.
- Sits between the bench/boot infrastructure and the CPU's PRF, RAT and free-list init ports.

Parameters:
- DATA_WIDTH, 32, register data width
- PHY_REGS, 64, number of physical registers
- PHY_WIDTH, 6, physical register index width (clog2 PHY_REGS)
- ARCH_REGS, 32, number of architectural registers; must be <= PHY_REGS
- ARCH_WIDTH, 5, architectural index width (clog2 ARCH_REGS)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin load sequence; sampled only in IDLE
- in_valid  in  1  load word valid
- in_ready  out  1  loader accepts word this cycle
- in_data  in  DATA_WIDTH  register value, in order x0 upward
- prf_we  out  1  PRF write enable
- prf_waddr  out  PHY_WIDTH  PRF write index
- prf_wdata  out  DATA_WIDTH  PRF write data
- rat_we  out  1  front/retire RAT write enable
- rat_arch  out  ARCH_WIDTH  RAT entry written
- rat_phys  out  PHY_WIDTH  physical mapping written
- fl_push  out  1  free-list push strobe
- fl_reg  out  PHY_WIDTH  physical register pushed
- busy  out  1  sequence in progress
- load_done  out  1  one-cycle pulse on completion
- cpu_hold  out  1  holds core in reset while high

Behaviour:
- Reset (async): state=IDLE, counters=0, all strobes 0, in_ready=0, busy=0, load_done=0, cpu_hold=1.
- All outputs are registered.
- FSM states: IDLE, LOAD, SEED, DONE.
- IDLE:
  - start=1 -> LOAD, idx=0, busy=1.
  - start ignored in every other state.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, the next cycle drives:
    - prf_we=1, prf_waddr=idx, prf_wdata=in_data
    - rat_we=1, rat_arch=idx, rat_phys=idx
  - idx=0 forces prf_wdata=0 regardless of in_data (x0 hardwired zero).
  - Back-to-back accepts give one write per cycle.
  - in_valid low inserts bubbles with no strobes.
  - When idx==ARCH_REGS-1 is accepted: in_ready drops the same edge, then -> SEED with fidx=ARCH_REGS.
  - in_valid in any other state is ignored; in_ready=0 there.
- SEED:
  - Each cycle: fl_push=1, fl_reg=fidx, then fidx++.
  - Covers ARCH_REGS..PHY_REGS-1 in ascending order, exactly PHY_REGS-ARCH_REGS pushes.
  - If ARCH_REGS==PHY_REGS, SEED is skipped with zero pushes.
- DONE (one cycle): load_done=1, busy=0, cpu_hold=0; then -> IDLE.
- cpu_hold stays 0 until the next reset or the next start.
- A new start re-asserts cpu_hold=1 the cycle after start.
- Latency with in_valid held high: ARCH_REGS accept cycles + (PHY_REGS-ARCH_REGS) seed cycles + 1 done cycle, measured from start to load_done.
- Default parameters: 32+32+1 = 65 cycles after LOAD entry.
- Counter widths:
  - idx is ARCH_WIDTH bits.
  - fidx is PHY_WIDTH+1 bits so the compare at PHY_REGS does not wrap.
- Reset mid-operation aborts immediately: cpu_hold=1, no further strobes. Partially written PRF/RAT contents are not cleared by this block.

Optional Feature:
- Macro: ARCH_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_WIDTH-1:0].
  - It holds the running XOR of all accepted in_data words, with x0's word included as received (pre-forcing).
  - Cleared on start and on reset; stable from load_done until the next start.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then start, stream x0..x31 = 32'h1000_0000+i with in_valid held high -> PRF writes at idx 0..31 in order (idx0 data=0), RAT[i]=i, load_done at cycle 65 after LOAD entry, cpu_hold falls with load_done.
- in_valid toggled 1/0 every cycle -> exactly 32 prf_we pulses, no write in bubble cycles, data order preserved, total LOAD span 63 cycles.
- After the last word -> 32 fl_push pulses with fl_reg = 32..63 consecutively, then load_done; no push before the last RAT write.
- start pulsed during LOAD at idx=10 -> ignored, sequence completes normally with 32 writes and 32 pushes.
- rst asserted at idx=17 -> same instant: strobes=0, cpu_hold=1, busy=0; a new start restarts at idx=0.
- With ARCH_LOADER_CHECKSUM_EN, words 32'hA5A5_0000^i -> checksum = XOR of all 32 words (32'h0000_0000 for this set), valid at load_done.
